// File: rtl/bcd_cnt10k_pkg.sv
// Shared constants and digit clamp helper for the four-digit BCD counter.
package bcd_cnt10k_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned NDIG    = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with load clamp and ripple carry/borrow out.
module bcd_digit
    import bcd_cnt10k_pkg::*;
(
    input  logic             CP,
    input  logic             CLR,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    input  logic             step,
    input  logic             up,
    input  logic             ci,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] q_next;

    always_comb begin
        q_next = q;
        if (up) begin
            q_next = (q == BCD_MAX) ? '0 : q + 4'd1;
        end else begin
            q_next = (q == '0) ? BCD_MAX : q - 4'd1;
        end
    end

    // Carry out when this digit is about to roll over in the current direction.
    assign co = ci && (up ? (q == BCD_MAX) : (q == '0));

    always_ff @(posedge CP) begin
        if (CLR) begin
            q <= '0;
        end else if (ld) begin
            q <= bcd_sat(d);
        end else if (step && ci) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_cnt10k.sv
// Four-digit BCD up/down counter with prescaler, parallel load and wrap strobes.
module bcd_cnt10k
    import bcd_cnt10k_pkg::*;
#(
    parameter int unsigned DIV = 50000000
) (
    input  logic        CP,
    input  logic        CLR,
    input  logic        EN,
    input  logic        UP,
    input  logic        LD,
    input  logic [15:0] D,
    output logic [15:0] Q,
    output logic        CO,
    output logic        BO
);

    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic          step;
    logic [NDIG:0] chain;

    assign step     = EN && (pre == PRE_LAST);
    assign chain[0] = 1'b1;

    always_ff @(posedge CP) begin
        if (CLR || LD) begin
            pre <= '0;
        end else if (EN) begin
            pre <= step ? '0 : pre + PW'(1);
        end
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit u_dig (
            .CP   (CP),
            .CLR  (CLR),
            .ld   (LD),
            .d    (D[i*BCD_W +: BCD_W]),
            .step (step),
            .up   (UP),
            .ci   (chain[i]),
            .q    (Q[i*BCD_W +: BCD_W]),
            .co   (chain[i+1])
        );
    end

    // A ripple out of the top digit on a step edge is the full-range wrap.
    always_ff @(posedge CP) begin
        if (CLR || LD) begin
            CO <= 1'b0;
            BO <= 1'b0;
        end else begin
            CO <= step && UP && chain[NDIG];
            BO <= step && !UP && chain[NDIG];
        end
    end

endmodule

// File: tb/tb_bcd_cnt10k.sv
// Directed bench: decimal reference model feeds a scoreboard checked each cycle.
module tb_bcd_cnt10k;

    logic        CP = 1'b0;
    logic        CLR, EN, UP, LD;
    logic [15:0] D;
    logic [15:0] q4, q1;
    logic        co4, bo4, co1, bo1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] q4;
        logic        co4;
        logic        bo4;
        logic [15:0] q1;
        logic        co1;
        logic        bo1;
    } exp_t;

    exp_t sb[$];

    int m_val[2];
    int m_pre[2];
    int m_co[2];
    int m_bo[2];
    int m_div[2] = '{4, 1};

    bcd_cnt10k #(.DIV(4)) dut4 (
        .CP(CP), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
        .Q(q4), .CO(co4), .BO(bo4)
    );

    bcd_cnt10k #(.DIV(1)) dut1 (
        .CP(CP), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
        .Q(q1), .CO(co1), .BO(bo1)
    );

    always #5 CP = ~CP;

    function automatic int clamp_dec(input logic [15:0] dv);
        int r = 0;
        for (int k = 3; k >= 0; k--) begin
            int n = int'(dv[k*4 +: 4]);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_edge(input int m);
        m_co[m] = 0;
        m_bo[m] = 0;
        if (CLR) begin
            m_val[m] = 0;
            m_pre[m] = 0;
        end else if (LD) begin
            m_val[m] = clamp_dec(D);
            m_pre[m] = 0;
        end else if (EN) begin
            if (m_pre[m] == m_div[m] - 1) begin
                m_pre[m] = 0;
                if (UP) begin
                    if (m_val[m] == 9999) begin m_val[m] = 0; m_co[m] = 1; end
                    else m_val[m] = m_val[m] + 1;
                end else begin
                    if (m_val[m] == 0) begin m_val[m] = 9999; m_bo[m] = 1; end
                    else m_val[m] = m_val[m] - 1;
                end
            end else begin
                m_pre[m] = m_pre[m] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, push the model prediction, clock, then pop and compare.
    task automatic cyc(input logic clr_v, input logic ld_v, input logic en_v,
                       input logic up_v, input logic [15:0] d_v);
        exp_t e;
        CLR = clr_v; LD = ld_v; EN = en_v; UP = up_v; D = d_v;
        model_edge(0);
        model_edge(1);
        sb.push_back('{to_bcd(m_val[0]), m_co[0][0], m_bo[0][0],
                       to_bcd(m_val[1]), m_co[1][0], m_bo[1][0]});
        @(posedge CP);
        #1;
        e = sb.pop_front();
        chk("q_div4",  q4, e.q4);
        chk("co_div4", {15'd0, co4}, {15'd0, e.co4});
        chk("bo_div4", {15'd0, bo4}, {15'd0, e.bo4});
        chk("q_div1",  q1, e.q1);
        chk("co_div1", {15'd0, co1}, {15'd0, e.co1});
        chk("bo_div1", {15'd0, bo1}, {15'd0, e.bo1});
        chk("no_co_bo_both", {15'd0, co4 & bo4}, 16'd0);
    endtask

    task automatic run(input int n, input logic en_v, input logic up_v);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, en_v, up_v, 16'h0000);
    endtask

    initial begin
        CLR = 1'b0; LD = 1'b0; EN = 1'b0; UP = 1'b1; D = 16'h0000;
        @(negedge CP);

        // 1: reset and first steps
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("reset_q", q4, 16'h0000);
        run(3, 1'b1, 1'b1);
        chk("pre_step_q", q4, 16'h0000);
        run(1, 1'b1, 1'b1);
        chk("first_step", q4, 16'h0001);
        run(4, 1'b1, 1'b1);
        chk("second_step", q4, 16'h0002);

        // 2: up wrap with carry strobe
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
        run(4, 1'b1, 1'b1);
        chk("up_9999", q4, 16'h9999);
        run(4, 1'b1, 1'b1);
        chk("up_wrap_q", q4, 16'h0000);
        chk("up_wrap_co", {15'd0, co4}, 16'd1);
        run(1, 1'b1, 1'b1);
        chk("co_one_cycle", {15'd0, co4}, 16'd0);

        // 3: decade borrow and down wrap
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100);
        run(4, 1'b1, 1'b0);
        chk("down_0099", q4, 16'h0099);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        run(4, 1'b1, 1'b0);
        chk("down_wrap_q", q4, 16'h9999);
        chk("down_wrap_bo", {15'd0, bo4}, 16'd1);
        run(1, 1'b1, 1'b0);
        chk("bo_one_cycle", {15'd0, bo4}, 16'd0);

        // 4: load on a step cycle clamps and discards the step
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        run(3, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hFA3C);
        chk("clamp_load", q4, 16'h9939);
        run(3, 1'b1, 1'b1);
        chk("pre_restart", q4, 16'h9939);
        run(1, 1'b1, 1'b1);
        chk("after_clamp_step", q4, 16'h9940);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1A3F);
        chk("load_en0", q4, 16'h1939);

        // 5: hold with EN low, UP toggled while frozen
        run(2, 1'b1, 1'b1);
        run(5, 1'b0, 1'b0);
        run(5, 1'b0, 1'b1);
        chk("hold_q", q4, 16'h1939);
        run(1, 1'b1, 1'b1);
        chk("hold_not_yet", q4, 16'h1939);
        run(1, 1'b1, 1'b1);
        chk("hold_resume", q4, 16'h1940);

        // 6: clear beats load mid-count; DIV=1 steps every enabled edge
        run(1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        chk("clr_over_ld", q4, 16'h0000);
        chk("clr_over_ld_div1", q1, 16'h0000);
        run(3, 1'b1, 1'b1);
        chk("clr_pre_zero", q4, 16'h0000);
        chk("div1_three", q1, 16'h0003);
        run(1, 1'b1, 1'b1);
        chk("clr_step", q4, 16'h0001);
        chk("div1_four", q1, 16'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
